// File: rtl/turn_signal_input.sv
// Turn-signal front end: synchronizes, debounces and edge-detects left/right/hazard buttons,
// then holds the active request in a 4-state FSM with toggle-cancel and timeout cancel.
module turn_signal_input #(
   parameter int DEB_BITS     = 20,
   parameter int TICK_BITS    = 24,
   parameter int CANCEL_TICKS = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_l,
   input  logic       btn_r,
   input  logic       btn_haz,
   output logic       l,
   output logic       r,
   output logic       haz_active,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LEFT   = 2'd1,
      RIGHT  = 2'd2,
      HAZARD = 2'd3
   } state_t;

   localparam int            CH_L    = 0;
   localparam int            CH_R    = 1;
   localparam int            CH_H    = 2;
   localparam logic [7:0]    LP_LAST = 8'(CANCEL_TICKS - 1);

   logic [2:0]                w_btn;
   logic [2:0]                r_sync1;
   logic [2:0]                r_sync2;
   logic [2:0]                r_stable;
   logic [2:0][DEB_BITS-1:0]  r_deb_cnt;
   logic [2:0]                w_press;

   assign w_btn = {btn_haz, btn_r, btn_l};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_stable  <= '0;
         r_deb_cnt <= '0;
      end else begin
         r_sync1 <= w_btn;
         r_sync2 <= r_sync1;
         for (int i = 0; i < 3; i++) begin
            if (r_sync2[i] == r_stable[i]) begin
               r_deb_cnt[i] <= '0;
            end else if (&r_deb_cnt[i]) begin
               r_stable[i]  <= r_sync2[i];
               r_deb_cnt[i] <= '0;
            end else begin
               r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   // A press is the cycle in which the debouncer is about to commit a 0->1 change.
   always_comb begin
      w_press = '0;
      for (int i = 0; i < 3; i++) begin
         w_press[i] = r_sync2[i] & ~r_stable[i] & (&r_deb_cnt[i]);
      end
   end

   state_t                r_state;
   state_t                w_state_nxt;
   logic [TICK_BITS-1:0]  r_presc;
   logic [7:0]            r_tick_cnt;
   logic                  w_tick;
   logic                  w_in_req;
   logic                  w_timeout;
   logic                  w_haz_evt;
   logic                  r_l;
   logic                  r_r;
   logic                  r_haz;

   assign w_tick    = &r_presc;
   assign w_in_req  = (r_state == LEFT) || (r_state == RIGHT);
   assign w_timeout = w_in_req && w_tick && (r_tick_cnt == LP_LAST);
   assign w_haz_evt = w_press[CH_H] | (w_press[CH_L] & w_press[CH_R]);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_haz_evt)          w_state_nxt = HAZARD;
            else if (w_press[CH_L]) w_state_nxt = LEFT;
            else if (w_press[CH_R]) w_state_nxt = RIGHT;
         end
         LEFT: begin
            if (w_haz_evt)          w_state_nxt = HAZARD;
            else if (w_press[CH_L]) w_state_nxt = IDLE;
            else if (w_press[CH_R]) w_state_nxt = RIGHT;
            else if (w_timeout)     w_state_nxt = IDLE;
         end
         RIGHT: begin
            if (w_haz_evt)          w_state_nxt = HAZARD;
            else if (w_press[CH_R]) w_state_nxt = IDLE;
            else if (w_press[CH_L]) w_state_nxt = LEFT;
            else if (w_timeout)     w_state_nxt = IDLE;
         end
         HAZARD: begin
            if (w_press[CH_H])      w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Every state change restarts the timeout, including a direct LEFT<->RIGHT swap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_presc    <= '0;
         r_tick_cnt <= '0;
         r_l        <= 1'b0;
         r_r        <= 1'b0;
         r_haz      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_l     <= (w_state_nxt == LEFT)  || (w_state_nxt == HAZARD);
         r_r     <= (w_state_nxt == RIGHT) || (w_state_nxt == HAZARD);
         r_haz   <= (w_state_nxt == HAZARD);
         if (w_state_nxt != r_state) begin
            r_presc    <= '0;
            r_tick_cnt <= '0;
         end else begin
            r_presc <= r_presc + 1'b1;
            if (!w_in_req)   r_tick_cnt <= '0;
            else if (w_tick) r_tick_cnt <= r_tick_cnt + 1'b1;
         end
      end
   end

   assign l          = r_l;
   assign r          = r_r;
   assign haz_active = r_haz;
   assign state_dbg  = r_state;

endmodule
